// File: rtl/boot_pkg.sv
// Shared types and constants for the program loader: FSM encoding, frame sync byte
// and the built-in default boot image.
package boot_pkg;

   typedef enum logic [2:0] {
      ST_INIT_WR = 3'd0,
      ST_INIT_NX = 3'd1,
      ST_RUN     = 3'd2,
      ST_LEN     = 3'd3,
      ST_DATA    = 3'd4,
      ST_CSUM    = 3'd5,
      ST_ERR     = 3'd6
   } loader_state_t;

   localparam logic [7:0] SYNC_BYTE = 8'h55;

   // Default image; any word not listed reads as zero.
   function automatic logic [15:0] default_img(input logic [31:0] idx);
      logic [15:0] w;
      w = 16'h0000;
      case (idx)
         32'd0:  w = 16'h7001;
         32'd1:  w = 16'h7102;
         32'd2:  w = 16'h7203;
         32'd3:  w = 16'h1012;
         32'd4:  w = 16'h2123;
         32'd5:  w = 16'h3034;
         32'd6:  w = 16'hA005;
         32'd7:  w = 16'hB10F;
         32'd8:  w = 16'hC0FF;
         32'd9:  w = 16'h5A5A;
         32'd10: w = 16'hFFFF;
         32'd11: w = 16'hE000;
         default: w = 16'h0000;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into DATA_W words and keeps the 8-bit running sum
// of every byte it accepts since the last clear.
module byte_packer #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              byte_en,
   input  logic [7:0]        byte_in,
   output logic [DATA_W-1:0] word,
   output logic              word_done,
   output logic [7:0]        sum
);

   localparam int BPW   = DATA_W / 8;
   localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(BPW - 1);

   logic [IDX_W-1:0] idx;

   assign word_done = byte_en && (idx == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
         sum <= 8'h00;
      end else if (clear) begin
         idx <= '0;
         sum <= 8'h00;
      end else if (byte_en) begin
         idx <= (idx == LAST) ? '0 : idx + 1'b1;
         sum <= sum + byte_in;
      end
   end

   generate
      if (BPW == 1) begin : g_one
         assign word = byte_in;
      end else begin : g_multi
         // Earlier bytes of the word; the newest byte always lands on top.
         logic [DATA_W-9:0] hist;
         assign word = {byte_in, hist};
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)       hist <= '0;
            else if (clear)   hist <= '0;
            else if (byte_en) hist <= word[DATA_W-1:8];
         end
      end
   endgenerate

endmodule

// File: rtl/prog_loader.sv
// Instruction-memory loader: writes the default image after reset or reload, then
// accepts framed UART downloads while holding the CPU in reset.
module prog_loader
   import boot_pkg::*;
#(
   parameter int ADDR_W  = 11,
   parameter int DATA_W  = 16,
   parameter int IMG_LEN = 16,
   parameter int TIMEOUT = 27_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              reload,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              mem_ce,
   output logic              mem_wre,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              boot_mode,
   output logic              cpu_rst_n,
   output logic              load_err,
   output logic [7:0]        words_loaded
);

   localparam int TCNT_W = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] LAST_IMG = ADDR_W'(IMG_LEN - 1);
   localparam logic [TCNT_W-1:0] TO_LAST  = TCNT_W'(TIMEOUT - 1);

   loader_state_t     state;
   logic [ADDR_W-1:0] load_addr;
   logic [7:0]        len;
   logic [7:0]        wcnt;
   logic [TCNT_W-1:0] tcnt;
   logic [DATA_W-1:0] rom_word;
   logic [DATA_W-1:0] pk_word;
   logic              pk_done;
   logic [7:0]        pk_sum;
   logic              is_sync;
   logic              pk_clear;
   logic              pk_en;

   assign mem_ce   = 1'b1;
   assign mem_addr = boot_mode ? load_addr : cpu_addr;

   always_comb rom_word = DATA_W'(default_img(32'(load_addr)));

   assign is_sync  = rx_valid && (rx_data == SYNC_BYTE);
   assign pk_clear = !reload && is_sync && (state == ST_RUN || state == ST_ERR);
   assign pk_en    = !reload && rx_valid && (state == ST_DATA);

   byte_packer #(.DATA_W(DATA_W)) u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (pk_clear),
      .byte_en   (pk_en),
      .byte_in   (rx_data),
      .word      (pk_word),
      .word_done (pk_done),
      .sum       (pk_sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_INIT_WR;
         load_addr    <= '0;
         len          <= 8'h00;
         wcnt         <= 8'h00;
         tcnt         <= '0;
         mem_wre      <= 1'b0;
         mem_din      <= '0;
         boot_mode    <= 1'b1;
         cpu_rst_n    <= 1'b0;
         load_err     <= 1'b0;
         words_loaded <= 8'h00;
      end else begin
         mem_wre <= 1'b0;
         if (reload) begin
            state     <= ST_INIT_WR;
            load_addr <= '0;
            tcnt      <= '0;
            boot_mode <= 1'b1;
            cpu_rst_n <= 1'b0;
            load_err  <= 1'b0;
         end else begin
            // A UART word write lasts one cycle; the address advances as it ends.
            if (mem_wre && state != ST_INIT_NX) load_addr <= load_addr + 1'b1;
            case (state)
               ST_INIT_WR: begin
                  mem_wre <= 1'b1;
                  mem_din <= rom_word;
                  state   <= ST_INIT_NX;
               end
               ST_INIT_NX: begin
                  if (load_addr == LAST_IMG) begin
                     state     <= ST_RUN;
                     boot_mode <= 1'b0;
                     cpu_rst_n <= 1'b1;
                  end else begin
                     load_addr <= load_addr + 1'b1;
                     state     <= ST_INIT_WR;
                  end
               end
               ST_RUN: begin
                  if (is_sync) begin
                     state     <= ST_LEN;
                     boot_mode <= 1'b1;
                     cpu_rst_n <= 1'b0;
                     load_addr <= '0;
                     tcnt      <= '0;
                  end
               end
               ST_LEN, ST_DATA, ST_CSUM: begin
                  if (rx_valid) begin
                     tcnt <= '0;
                     if (state == ST_LEN) begin
                        if (rx_data == 8'h00) begin
                           state    <= ST_ERR;
                           load_err <= 1'b1;
                        end else begin
                           len   <= rx_data;
                           wcnt  <= 8'h00;
                           state <= ST_DATA;
                        end
                     end else if (state == ST_DATA) begin
                        if (pk_done) begin
                           mem_wre <= 1'b1;
                           mem_din <= pk_word;
                           if (wcnt == len - 8'd1) state <= ST_CSUM;
                           else                    wcnt  <= wcnt + 8'd1;
                        end
                     end else if (rx_data == pk_sum) begin
                        state        <= ST_RUN;
                        words_loaded <= len;
                        boot_mode    <= 1'b0;
                        cpu_rst_n    <= 1'b1;
                        load_err     <= 1'b0;
                     end else begin
                        state    <= ST_ERR;
                        load_err <= 1'b1;
                     end
                  end else if (tcnt == TO_LAST) begin
                     state    <= ST_ERR;
                     load_err <= 1'b1;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
               ST_ERR: begin
                  boot_mode <= 1'b1;
                  cpu_rst_n <= 1'b0;
                  if (is_sync) begin
                     state     <= ST_LEN;
                     load_addr <= '0;
                     tcnt      <= '0;
                  end
               end
               default: state <= ST_INIT_WR;
            endcase
         end
      end
   end

endmodule
